// File: rtl/keypad_pkg.sv
// Shared types and default 4x3 keymap for the grid keypad navigator.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_REL = 2'd1,
        ARMED    = 2'd2
    } arm_state_t;

    typedef enum logic [2:0] {
        DIR_NONE = 3'd0,
        DIR_U    = 3'd1,
        DIR_D    = 3'd2,
        DIR_L    = 3'd3,
        DIR_R    = 3'd4
    } dir_t;

    localparam int          DEF_ROWS       = 32'sd4;
    localparam int          DEF_COLS       = 32'sd3;
    localparam int          DEF_KEY_W      = 32'sd4;
    localparam logic [47:0] DEF_KEYMAP     = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6,
                                              4'd7, 4'd8, 4'd9, 4'd10, 4'd0, 4'd11};
    localparam logic [3:0]  DEF_ENTER_CODE = 4'd11;
    localparam logic [3:0]  DEF_BKSP_CODE  = 4'd10;

    // Index width for n entries, never narrower than one bit.
    function automatic int idxWidth(input int n);
        return (n > 32'sd2) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/keypad_repeat_timer.sv
// Hold-to-repeat tick generator: first tick RPT_DELAY cycles after restart, then every RPT_PERIOD.
module keypad_repeat_timer
    import keypad_pkg::*;
#(
    parameter int RPT_DELAY  = 50_000_000,
    parameter int RPT_PERIOD = 15_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic held,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = idxWidth((RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(RPT_DELAY - 32'sd1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(RPT_PERIOD - 32'sd1);

    logic [CNT_W-1:0] cnt;
    logic             first;

    // Tick when the held interval for the current phase has elapsed
    always_comb begin
        tick = held & ~restart & (cnt == (first ? DLY_LAST : PER_LAST));
    end

    // Interval counter; any restart or release returns to the initial-delay phase
    always_ff @(posedge clk) begin
        if (!reset_n || restart || !held) begin
            cnt   <= {CNT_W{1'b0}};
            first <= 1'b1;
        end else if (tick) begin
            cnt   <= {CNT_W{1'b0}};
            first <= 1'b0;
        end else begin
            cnt   <= cnt + CNT_W'(1);
            first <= first;
        end
    end

endmodule

// File: rtl/keypad_nav_engine.sv
// Grid keypad cursor navigator and selector with arming FSM.
// Optional hold-to-repeat navigation is built when AUTO_REPEAT_EN is defined.
module keypad_nav_engine
    import keypad_pkg::*;
#(
    parameter int                          ROWS       = DEF_ROWS,
    parameter int                          COLS       = DEF_COLS,
    parameter int                          KEY_W      = DEF_KEY_W,
    parameter logic [ROWS*COLS*KEY_W-1:0]  KEYMAP     = DEF_KEYMAP,
    parameter logic [KEY_W-1:0]            ENTER_CODE = DEF_ENTER_CODE,
    parameter logic [KEY_W-1:0]            BKSP_CODE  = DEF_BKSP_CODE,
    parameter bit                          WRAP       = 1'b1,
    parameter int                          RPT_DELAY  = 50_000_000,
    parameter int                          RPT_PERIOD = 15_000_000
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       enable,
    input  logic                       btn_u,
    input  logic                       btn_d,
    input  logic                       btn_l,
    input  logic                       btn_r,
    input  logic                       btn_c,
    input  logic                       cursor_home,
    output logic [idxWidth(ROWS)-1:0]  row_pos,
    output logic [idxWidth(COLS)-1:0]  col_pos,
    output logic [KEY_W-1:0]           key_code,
    output logic                       key_valid,
    output logic                       digit_pressed,
    output logic                       enter_pressed,
    output logic                       backspace_pressed,
    output logic                       armed
);

    localparam int RW    = idxWidth(ROWS);
    localparam int CW    = idxWidth(COLS);
    localparam int CELLS = ROWS * COLS;
    localparam int IW    = idxWidth(CELLS);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 32'sd1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 32'sd1);

    arm_state_t       armState, armNext;
    logic             armedS;
    logic [4:0]       btnLvl, btnPrev, btnRise;   // {c, r, l, d, u}
    logic [RW-1:0]    rowPos, rowNext;
    logic [CW-1:0]    colPos, colNext;
    logic [KEY_W-1:0] keyCode, selCode;
    logic             keyValid, digitP, enterP, bkspP, select;
    logic [IW-1:0]    cellIdx;
    dir_t             riseDir, moveDir;

    assign btnLvl  = {btn_c, btn_r, btn_l, btn_d, btn_u};
    assign btnRise = btnLvl & ~btnPrev;
    assign select  = btnRise[4] & enable & (armState == ARMED);
    assign cellIdx = IW'(rowPos) * IW'(COLS) + IW'(colPos);

    // Arm state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            armState <= IDLE;
        end else begin
            armState <= armNext;
        end
    end

    // Arm next state: btn_c must be seen released before selection is armed
    always_comb begin
        armNext = armState;
        if (!enable) begin
            armNext = IDLE;
        end else begin
            case (armState)
                IDLE:     armNext = WAIT_REL;
                WAIT_REL: armNext = btn_c ? WAIT_REL : ARMED;
                ARMED:    armNext = ARMED;
                default:  armNext = IDLE;
            endcase
        end
    end

    // Arm output decode
    always_comb begin
        armedS = (armState == ARMED);
    end

    // Highest-priority fresh direction press: U > D > L > R
    always_comb begin
        riseDir = DIR_NONE;
        if (!enable)         riseDir = DIR_NONE;
        else if (btnRise[0]) riseDir = DIR_U;
        else if (btnRise[1]) riseDir = DIR_D;
        else if (btnRise[2]) riseDir = DIR_L;
        else if (btnRise[3]) riseDir = DIR_R;
        else                 riseDir = DIR_NONE;
    end

`ifdef AUTO_REPEAT_EN
    dir_t trackDir;
    logic trackLvl, held, restart, tick;

    // Current level of the direction being tracked for repeat
    always_comb begin
        case (trackDir)
            DIR_U:   trackLvl = btn_u;
            DIR_D:   trackLvl = btn_d;
            DIR_L:   trackLvl = btn_l;
            DIR_R:   trackLvl = btn_r;
            default: trackLvl = 1'b0;
        endcase
    end

    assign restart = (riseDir != DIR_NONE);
    assign held    = enable & ~cursor_home & trackLvl;

    // Repeat tracker: follows each winning press, dropped on release/disable/home
    always_ff @(posedge clk) begin
        if (!reset_n || !enable || cursor_home) begin
            trackDir <= DIR_NONE;
        end else if (restart) begin
            trackDir <= riseDir;
        end else if (!trackLvl) begin
            trackDir <= DIR_NONE;
        end else begin
            trackDir <= trackDir;
        end
    end

    keypad_repeat_timer #(
        .RPT_DELAY  (RPT_DELAY),
        .RPT_PERIOD (RPT_PERIOD)
    ) uRepeatTimer (
        .clk     (clk),
        .reset_n (reset_n),
        .held    (held),
        .restart (restart),
        .tick    (tick)
    );

    assign moveDir = restart ? riseDir : (tick ? trackDir : DIR_NONE);
`else
    assign moveDir = riseDir;
`endif

    // Next cursor position; home wins over any move
    always_comb begin
        rowNext = rowPos;
        colNext = colPos;
        if (cursor_home) begin
            rowNext = {RW{1'b0}};
            colNext = {CW{1'b0}};
        end else begin
            case (moveDir)
                DIR_U: rowNext = (rowPos == {RW{1'b0}}) ? (WRAP ? ROW_MAX : rowPos) : rowPos - RW'(1);
                DIR_D: rowNext = (rowPos == ROW_MAX) ? (WRAP ? {RW{1'b0}} : rowPos) : rowPos + RW'(1);
                DIR_L: colNext = (colPos == {CW{1'b0}}) ? (WRAP ? COL_MAX : colPos) : colPos - CW'(1);
                DIR_R: colNext = (colPos == COL_MAX) ? (WRAP ? {CW{1'b0}} : colPos) : colPos + CW'(1);
                default: begin
                    rowNext = rowPos;
                    colNext = colPos;
                end
            endcase
        end
    end

    // Keymap lookup at the pre-move cursor; cell(0,0) sits in the MSBs
    always_comb begin
        selCode = {KEY_W{1'b0}};
        for (int i = 0; i < CELLS; i++) begin
            if (cellIdx == IW'(i)) selCode = KEYMAP[(CELLS - 1 - i) * KEY_W +: KEY_W];
            else                   selCode = selCode;
        end
    end

    // Registered cursor, key code, event pulses and button history
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            btnPrev  <= btnLvl;
            rowPos   <= {RW{1'b0}};
            colPos   <= {CW{1'b0}};
            keyCode  <= {KEY_W{1'b0}};
            keyValid <= 1'b0;
            digitP   <= 1'b0;
            enterP   <= 1'b0;
            bkspP    <= 1'b0;
        end else begin
            btnPrev  <= btnLvl;
            rowPos   <= rowNext;
            colPos   <= colNext;
            keyCode  <= select ? selCode : keyCode;
            keyValid <= select;
            enterP   <= select & (selCode == ENTER_CODE);
            bkspP    <= select & (selCode != ENTER_CODE) & (selCode == BKSP_CODE);
            digitP   <= select & (selCode != ENTER_CODE) & (selCode != BKSP_CODE);
        end
    end

    assign row_pos           = rowPos;
    assign col_pos           = colPos;
    assign key_code          = keyCode;
    assign key_valid         = keyValid;
    assign digit_pressed     = digitP;
    assign enter_pressed     = enterP;
    assign backspace_pressed = bkspP;
    assign armed             = armedS;

endmodule
